// File: rtl/arith_arb.sv
// arith_arb -- two requesters share one arithmetic unit (adder plus multiplier).
//
// Ports:
//   clk, reset          clock; synchronous active-high reset
//   reqN_valid          requester N has an operation pending (N = 0, 1)
//   reqN_op             0 = add, 1 = multiply
//   reqN_a, reqN_b      operands, W bits each
//   reqN_cin            carry-in, used for add only
//   reqN_ready          requester N accepted this cycle (handshake with valid)
//   resp_valid          response available
//   resp_id             requester that owns the response
//   resp_result         add sum, or low W bits of the product
//   resp_cout           add carry-out, or multiply overflow flag
//   resp_ready          consumer takes the response this cycle
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | no operation in flight; grant computed combinationally
// BUSY  | operands latched; the result is registered at the next edge
// DONE  | response presented; held until resp_ready is sampled high

module arith_arb #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         req0_valid,
  input  logic         req0_op,
  input  logic [W-1:0] req0_a,
  input  logic [W-1:0] req0_b,
  input  logic         req0_cin,
  output logic         req0_ready,
  input  logic         req1_valid,
  input  logic         req1_op,
  input  logic [W-1:0] req1_a,
  input  logic [W-1:0] req1_b,
  input  logic         req1_cin,
  output logic         req1_ready,
  output logic         resp_valid,
  output logic         resp_id,
  output logic [W-1:0] resp_result,
  output logic         resp_cout,
  input  logic         resp_ready
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         state, state_nxt;
  logic           last_grant;
  logic           gnt0, gnt1;

  logic           op_q;
  logic           cin_q;
  logic           id_q;
  logic [W-1:0]   a_q, b_q;

  logic [W:0]     sum;
  logic [2*W-1:0] prod;
  logic [W-1:0]   res_nxt;
  logic           cout_nxt;

  // Grant and next-state. Under contention the requester that did not win
  // last time is served; readies are masked during reset so nothing is
  // accepted in a reset cycle even if the FSM happens to sit in IDLE.
  always_comb begin
    state_nxt  = state;
    gnt0       = 1'b0;
    gnt1       = 1'b0;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    case (state)
      IDLE: begin
        if (req0_valid && (!req1_valid || last_grant)) begin
          gnt0 = 1'b1;
        end else if (req1_valid) begin
          gnt1 = 1'b1;
        end
        req0_ready = gnt0 && !reset;
        req1_ready = gnt1 && !reset;
        if (gnt0 || gnt1) begin
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        state_nxt = DONE;
      end
      DONE: begin
        if (resp_ready) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Shared arithmetic on the latched operands.
  always_comb begin
    sum      = {1'b0, a_q} + {1'b0, b_q} + {{W{1'b0}}, cin_q};
    prod     = {{W{1'b0}}, a_q} * {{W{1'b0}}, b_q};
    res_nxt  = op_q ? prod[W-1:0] : sum[W-1:0];
    cout_nxt = op_q ? (|prod[2*W-1:W]) : sum[W];
  end

  assign resp_valid = (state == DONE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      last_grant  <= 1'b1;
      op_q        <= 1'b0;
      cin_q       <= 1'b0;
      id_q        <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      resp_id     <= 1'b0;
      resp_result <= '0;
      resp_cout   <= 1'b0;
    end else begin
      state <= state_nxt;
      // In IDLE a grant is always a handshake, since ready follows the grant.
      if (gnt0) begin
        op_q       <= req0_op;
        a_q        <= req0_a;
        b_q        <= req0_b;
        cin_q      <= req0_cin;
        id_q       <= 1'b0;
        last_grant <= 1'b0;
      end else if (gnt1) begin
        op_q       <= req1_op;
        a_q        <= req1_a;
        b_q        <= req1_b;
        cin_q      <= req1_cin;
        id_q       <= 1'b1;
        last_grant <= 1'b1;
      end
      // Response fields change only on BUSY->DONE, so they stay stable in
      // DONE and keep their last values after the response is taken.
      if (state == BUSY) begin
        resp_id     <= id_q;
        resp_result <= res_nxt;
        resp_cout   <= cout_nxt;
      end
    end
  end

endmodule
